// File: rtl/multi_input_conditioner.sv
// multi_input_conditioner: per-channel synchroniser, debounce filter and
// edge detector for noisy board inputs. Each channel also keeps sticky rise
// and fall event flags with a per-channel clear. A single registered interrupt
// reports any pending flag.
module multi_input_conditioner #(
    parameter int CHANNELS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int WAITTIME     = 3,
    parameter int COUNTERWIDTH = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    input  logic [CHANNELS-1:0] clear_events,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic [CHANNELS-1:0] rise_event,
    output logic [CHANNELS-1:0] fall_event,
    output logic                irq
);

    // Terminal count: a new level is accepted on its WAITTIME-th consecutive differing cycle.
    localparam logic [COUNTERWIDTH-1:0] CNT_LAST = COUNTERWIDTH'(WAITTIME - 1);
    localparam logic [COUNTERWIDTH-1:0] CNT_ONE  = COUNTERWIDTH'(1);

    logic [CHANNELS-1:0]     sync_r     [SYNC_STAGES];
    logic [COUNTERWIDTH-1:0] cnt_r      [CHANNELS];
    logic [COUNTERWIDTH-1:0] cnt_next_s [CHANNELS];
    logic [CHANNELS-1:0]     stable_s;
    logic [CHANNELS-1:0]     differ_s;
    logic [CHANNELS-1:0]     accept_s;
    logic [CHANNELS-1:0]     rise_s;
    logic [CHANNELS-1:0]     fall_s;

    // Debounce decision per channel: count consecutive cycles the synchronised level disagrees with the accepted one.
    always_comb begin
        stable_s = sync_r[SYNC_STAGES-1];
        differ_s = stable_s ^ conditioned;
        accept_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next_s[i] = '0;
            if (differ_s[i]) begin
                if (cnt_r[i] == CNT_LAST) begin
                    accept_s[i]   = 1'b1;
                    cnt_next_s[i] = '0;
                end else begin
                    cnt_next_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else begin
                cnt_next_s[i] = '0;
            end
        end
        rise_s = accept_s & stable_s;
        fall_s = accept_s & ~stable_s;
    end

    // Synchroniser chains: stage 0 captures the raw pins, later stages shift the value along.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
        end else begin
            sync_r[0] <= noisysignal;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Debounce counters; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    // Accepted level and one-cycle edge pulses, updated on the same edge the new level is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            conditioned  <= '0;
            positiveedge <= '0;
            negativeedge <= '0;
        end else begin
            conditioned  <= conditioned ^ accept_s;
            positiveedge <= rise_s;
            negativeedge <= fall_s;
        end
    end

    // Sticky event flags (a set on the clearing cycle wins) and the interrupt, one cycle behind the flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_event <= '0;
            fall_event <= '0;
            irq        <= 1'b0;
        end else begin
            rise_event <= (rise_event & ~clear_events) | rise_s;
            fall_event <= (fall_event & ~clear_events) | fall_s;
            irq        <= |(rise_event | fall_event);
        end
    end

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Self-checking bench for multi_input_conditioner (4 channels, 2 sync stages,
// wait time 3). It runs directed sequences, a table of reset-release vectors,
// and random stimulus compared every cycle against a sliding-window reference model.
module tb_multi_input_conditioner;

    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int WT   = 3;
    localparam int HLEN = SS + WT - 1;

    logic          clk;
    logic          reset;
    logic [CH-1:0] noisysignal;
    logic [CH-1:0] clear_events;
    logic [CH-1:0] conditioned;
    logic [CH-1:0] positiveedge;
    logic [CH-1:0] negativeedge;
    logic [CH-1:0] rise_event;
    logic [CH-1:0] fall_event;
    logic          irq;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    multi_input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .WAITTIME(WT), .COUNTERWIDTH(3)
    ) dut (
        .clk(clk), .reset(reset), .noisysignal(noisysignal), .clear_events(clear_events),
        .conditioned(conditioned), .positiveedge(positiveedge), .negativeedge(negativeedge),
        .rise_event(rise_event), .fall_event(fall_event), .irq(irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: hist[k] is the raw input sampled k+1 edges ago. A channel
    // accepts a new level when the WT most recent synchronised samples all differ
    // from its current level.
    typedef struct packed {
        logic [HLEN-1:0][CH-1:0] hist;
        logic [CH-1:0] cond;
        logic [CH-1:0] pos;
        logic [CH-1:0] neg;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          irq;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_step(mstate_t c, logic rst, logic [CH-1:0] nin, logic [CH-1:0] clr);
        mstate_t       n;
        logic [CH-1:0] acc;
        n = '0;
        if (rst) return n;
        acc = '1;
        for (int ch = 0; ch < CH; ch++)
            for (int w = 0; w < WT; w++)
                if (c.hist[SS-1+w][ch] == c.cond[ch]) acc[ch] = 1'b0;
        n.cond = c.cond ^ acc;
        n.pos  = acc & ~c.cond;
        n.neg  = acc & c.cond;
        n.rise = (c.rise & ~clr) | n.pos;
        n.fall = (c.fall & ~clr) | n.neg;
        n.irq  = |(c.rise | c.fall);
        n.hist = {c.hist[HLEN-2:0], nin};
        return n;
    endfunction

    always @(posedge clk) m <= model_step(m, reset, noisysignal, clear_events);

    function automatic logic [31:0] outs();
        return {11'b0, conditioned, positiveedge, negativeedge, rise_event, fall_event, irq};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (chk_en)
            check($sformatf("model@%0t", $time), outs(),
                  {11'b0, m.cond, m.pos, m.neg, m.rise, m.fall, m.irq});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] noisy;
        logic [3:0] clr;
        int         n;
        logic [3:0] cond;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       irq;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{4'b1010, 4'b0000, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[1] = '{4'b1010, 4'b0000, 5, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 1'b0};
        tbl[2] = '{4'b1010, 4'b0000, 6, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 1'b1};
        tbl[3] = '{4'b0110, 4'b0000, 5, 4'b0110, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 1'b0};
        tbl[4] = '{4'b0000, 4'b0000, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[5] = '{4'b1111, 4'b0000, 7, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1};
        tbl[6] = '{4'b1010, 4'b1111, 5, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 1'b0};
        tbl[7] = '{4'b1010, 4'b1111, 6, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        tbl[8] = '{4'b1010, 4'b1111, 7, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[9] = '{4'b0101, 4'b0100, 6, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1};

        reset        = 1'b1;
        noisysignal  = 4'b1111;
        clear_events = 4'b0000;

        // 1: reset held, release with all inputs high.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_en = 1'b1;
            check("t1_reset_outs", outs(), 32'd0);
        end
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("t1_cond_early", 32'(conditioned), 32'(4'b0000));
        end
        tick();
        check("t1_cond", 32'(conditioned), 32'(4'b1111));
        check("t1_pos", 32'(positiveedge), 32'(4'b1111));
        check("t1_rise", 32'(rise_event), 32'(4'b1111));
        check("t1_irq_lag", 32'(irq), 32'(1'b0));
        tick();
        check("t1_pos_drop", 32'(positiveedge), 32'(4'b0000));
        check("t1_irq", 32'(irq), 32'(1'b1));

        // 2: channel 0 low, then a 0->1 step.
        noisysignal[0] = 1'b0;
        repeat (6) tick();
        check("t2_fall0", 32'(conditioned), 32'(4'b1110));
        noisysignal[0] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("t2_cond_early", 32'(conditioned), 32'(4'b1110));
        end
        tick();
        check("t2_cond", 32'(conditioned), 32'(4'b1111));
        check("t2_pos", 32'(positiveedge), 32'(4'b0001));
        check("t2_neg", 32'(negativeedge), 32'(4'b0000));
        tick();
        check("t2_pos_one_cycle", 32'(positiveedge), 32'(4'b0000));

        // 3: channel 1 chatters every 7 ns (ten toggles, ending at its original level), then a 2-cycle dip.
        for (int k = 0; k < 10; k++) begin
            #7;
            noisysignal[1] = ~noisysignal[1];
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            check("t3_chatter_cond", 32'(conditioned), 32'(4'b1111));
            check("t3_chatter_edges", 32'({positiveedge[1], negativeedge[1]}), 32'(2'b00));
        end
        noisysignal[1] = 1'b0;
        tick();
        tick();
        noisysignal[1] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            check("t3_short_pulse", 32'({conditioned[1], negativeedge[1]}), 32'(2'b10));
        end

        // 4: channel 2 falls with clear asserted on the same edge; set wins.
        noisysignal[2] = 1'b0;
        repeat (4) tick();
        clear_events = 4'b0100;
        tick();
        check("t4_cond", 32'(conditioned), 32'(4'b1011));
        check("t4_neg", 32'(negativeedge), 32'(4'b0100));
        check("t4_fall_set_wins", 32'(fall_event), 32'(4'b0101));
        check("t4_rise_cleared", 32'(rise_event), 32'(4'b1011));
        clear_events = 4'b0000;
        tick();
        check("t4_fall_held", 32'(fall_event), 32'(4'b0101));
        clear_events = 4'b1111;
        tick();
        check("t4_flags_clear", 32'({rise_event, fall_event}), 32'(8'h00));
        check("t4_irq_still", 32'(irq), 32'(1'b1));
        clear_events = 4'b0000;
        tick();
        check("t4_irq_drop", 32'(irq), 32'(1'b0));

        // 5: channels 0 and 3 change in the same cycle, opposite directions.
        noisysignal[0] = 1'b0;
        repeat (6) tick();
        noisysignal[0] = 1'b1;
        noisysignal[3] = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("t5_no_edge_early", 32'({positiveedge, negativeedge}), 32'(8'h00));
        end
        tick();
        check("t5_pos", 32'(positiveedge), 32'(4'b0001));
        check("t5_neg", 32'(negativeedge), 32'(4'b1000));
        check("t5_cond", 32'(conditioned), 32'(4'b0011));

        // 6: reset on edge 3 of a debounce; the latency restarts after release.
        noisysignal = 4'b1100;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_reset_outs", outs(), 32'd0);
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("t6_cond_early", 32'(conditioned), 32'(4'b0000));
        end
        tick();
        check("t6_cond", 32'(conditioned), 32'(4'b1100));
        check("t6_pos", 32'(positiveedge), 32'(4'b1100));

        // Table: reset, release with a fixed input and clear, and sample after n edges.
        for (int i = 0; i < 10; i++) begin
            reset        = 1'b1;
            noisysignal  = tbl[i].noisy;
            clear_events = tbl[i].clr;
            tick();
            tick();
            reset = 1'b0;
            repeat (tbl[i].n) tick();
            check($sformatf("vec%0d", i), outs(),
                  {11'b0, tbl[i].cond, tbl[i].pos, tbl[i].neg, tbl[i].rise, tbl[i].fall, tbl[i].irq});
        end
        clear_events = 4'b0000;

        // Random phase: level changes, sub-cycle glitches, clears and occasional resets.
        for (int c = 0; c < 800; c++) begin
            logic [CH-1:0] flip;
            logic [CH-1:0] glitch;
            logic [CH-1:0] lvl;
            flip   = '0;
            glitch = '0;
            for (int b = 0; b < CH; b++) begin
                if ($urandom_range(0, 5) == 0) flip[b] = 1'b1;
                if ($urandom_range(0, 7) == 0) glitch[b] = 1'b1;
                clear_events[b] = ($urandom_range(0, 7) == 0);
            end
            reset       = ($urandom_range(0, 199) == 0);
            lvl         = noisysignal ^ flip;
            noisysignal = lvl ^ glitch;
            #($urandom_range(1, 7));
            noisysignal = lvl;
            tick();
        end

        reset        = 1'b0;
        clear_events = 4'b0000;
        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
